// File: rtl/memory_access.sv
// Memory stage: one req/ack data-memory transaction per load/store, load
// alignment/extension, and the writeback port. Stalls upstream while busy.
module memory_access #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_v,
  input  logic [3:0]  minst,
  input  logic [31:0] rd_data,
  input  logic [31:0] st_data,
  input  logic [4:0]  rd,
  input  logic        rdm_v,
  output logic        stall_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_v,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_m
);
  localparam int CW = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  state_t state;

  logic [CW-1:0] cnt;
  logic [2:0]    p_f3;
  logic [1:0]    p_lo;
  logic [4:0]    p_rd;
  logic          p_rdm_v;
  logic          sk_v;
  logic [4:0]    sk_rd;
  logic [31:0]   sk_data;

  logic          capture, is_mem, legal, misal, ld_wb, nm_wb;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new, ld_ext;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  // Handshake: upstream op is taken when in_v && !stall_m; the bus
  // transaction completes on the cycle dmem_ack is high while dmem_req is high.
  assign stall_m = (state == BUSY) && !dmem_ack;
  assign capture = in_v && !stall_m;
  assign is_mem  = (minst[3:2] != 2'b11);
  assign misal   = ((minst[1:0] == 2'b01) && rd_data[0]) ||
                   ((minst[1:0] == 2'b10) && (rd_data[1:0] != 2'b00));
  assign ld_wb   = (state == BUSY) && dmem_ack && !dmem_we && p_rdm_v;
  assign nm_wb   = capture && !is_mem && rdm_v;

  always_comb begin
    legal     = 1'b0;
    be_new    = 4'b1111;
    wdata_new = st_data;
    case (minst)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    case (minst[1:0])
      2'b00: begin
        be_new    = 4'b0001 << rd_data[1:0];
        wdata_new = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << rd_data[1:0];
        wdata_new = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_b = 8'(dmem_rdata >> {p_lo, 3'b000});
    ld_h = p_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (p_f3)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {24'd0, ld_b};
      3'b101:  ld_ext = {16'd0, ld_h};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_v       <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      err_m      <= 1'b0;
      p_f3       <= '0;
      p_lo       <= '0;
      p_rd       <= '0;
      p_rdm_v    <= 1'b0;
      sk_v       <= 1'b0;
      sk_rd      <= '0;
      sk_data    <= '0;
    end else begin
      wb_v  <= 1'b0;
      err_m <= 1'b0;
      if (state == BUSY) begin
        if (dmem_ack) begin
          state    <= IDLE;
          dmem_req <= 1'b0;
          cnt      <= '0;
        end else if (cnt == LAST) begin
          state    <= IDLE;
          dmem_req <= 1'b0;
          err_m    <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // A load ack and a non-memory op taken in the same cycle both want the
      // port; the older load goes first and the ALU result waits in the skid.
      if (sk_v) begin
        wb_v    <= 1'b1;
        wb_rd   <= sk_rd;
        wb_data <= sk_data;
      end else if (ld_wb) begin
        wb_v    <= 1'b1;
        wb_rd   <= p_rd;
        wb_data <= ld_ext;
      end else if (capture && !is_mem) begin
        wb_v    <= rdm_v;
        wb_rd   <= rd;
        wb_data <= rd_data;
      end
      sk_v <= (sk_v || ld_wb) && nm_wb;
      if (nm_wb) begin
        sk_rd   <= rd;
        sk_data <= rd_data;
      end
      if (capture && is_mem) begin
        if (!legal || misal) begin
          err_m <= 1'b1;
        end else begin
          state      <= BUSY;
          cnt        <= '0;
          dmem_req   <= 1'b1;
          dmem_we    <= minst[3];
          dmem_addr  <= {rd_data[31:2], 2'b00};
          dmem_be    <= be_new;
          dmem_wdata <= wdata_new;
          p_f3       <= minst[2:0];
          p_lo       <= rd_data[1:0];
          p_rd       <= rd;
          p_rdm_v    <= rdm_v;
        end
      end
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed cycle-exact cases, then random traffic
// against a byte-level memory model with an in-order writeback scoreboard.
module tb_memory_access;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_v;
  logic [3:0]  minst;
  logic [31:0] rd_data, st_data;
  logic [4:0]  rd;
  logic        rdm_v;
  logic        stall_m, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_v;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_m;

  logic        resp_en = 1'b0, mon_en = 1'b0;
  logic        dir_ack = 1'b0, resp_ack;
  logic [31:0] dir_rdata = '0, resp_rdata;
  assign dmem_ack   = resp_en ? resp_ack : dir_ack;
  assign dmem_rdata = resp_en ? resp_rdata : dir_rdata;

  memory_access #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .in_v(in_v), .minst(minst), .rd_data(rd_data),
    .st_data(st_data), .rd(rd), .rdm_v(rdm_v), .stall_m(stall_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_v(wb_v), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_m(err_m)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int err_seen = 0, exp_err = 0;

  typedef struct {int d; logic [31:0] addr; logic we;} req_t;
  req_t        req_q[$];
  logic [36:0] exp_q[$];
  logic [31:0] ref_mem[16], bus_mem[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] mi, input logic [31:0] a, input logic [31:0] st,
                       input logic [4:0] r, input logic v);
    in_v = 1'b1; minst = mi; rd_data = a; st_data = st; rd = r; rdm_v = v;
  endtask

  task automatic dir_op(input string tag, input logic [3:0] mi, input logic [31:0] a,
                        input logic [31:0] st, input logic [31:0] rdata, input int d,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic exp_wb, input logic [31:0] exp_data);
    drive(mi, a, st, 5'd7, 1'b1);
    step();
    in_v = 1'b0;
    check({tag, "_req"}, dmem_req, 1);
    check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    check({tag, "_we"}, dmem_we, mi[3]);
    check({tag, "_be"}, dmem_be, exp_be);
    if (mi[3]) check({tag, "_wdata"}, dmem_wdata, exp_wd);
    for (int k = 0; k < d; k++) begin
      check({tag, "_stall"}, stall_m, 1);
      step();
    end
    dir_ack = 1'b1;
    dir_rdata = rdata;
    #1;
    check({tag, "_stall_ack"}, stall_m, 0);
    step();
    dir_ack = 1'b0;
    check({tag, "_req_drop"}, dmem_req, 0);
    check({tag, "_wb_v"}, wb_v, exp_wb);
    if (exp_wb) begin
      check({tag, "_wb_data"}, wb_data, exp_data);
      check({tag, "_wb_rd"}, wb_rd, 7);
    end
    step();
    check({tag, "_wb_pulse"}, wb_v, 0);
  endtask

  task automatic dir_err(input string tag, input logic [3:0] mi, input logic [31:0] a);
    drive(mi, a, 32'h0, 5'd9, 1'b1);
    step();
    in_v = 1'b0;
    check({tag, "_req"}, dmem_req, 0);
    check({tag, "_err"}, err_m, 1);
    check({tag, "_wb_v"}, wb_v, 0);
    check({tag, "_stall"}, stall_m, 0);
    step();
    check({tag, "_err_pulse"}, err_m, 0);
    check({tag, "_wb_v2"}, wb_v, 0);
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    return ref_mem[a[5:2]][8*a[1:0] +: 8];
  endfunction

  // Reference model: decides the outcome of each accepted op at ISA level.
  task automatic model_op(input logic [3:0] mi, input logic [31:0] a, input logic [31:0] st,
                          input logic [4:0] r, input logic v, input int d);
    int nb;
    logic [31:0] val;
    logic [31:0] b;
    req_t q;
    if (mi[3:2] == 2'b11) begin
      if (v) exp_q.push_back({r, a});
      return;
    end
    nb = 1 << mi[1:0];
    if (!(mi inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10}) || (a % nb) != 0) begin
      exp_err++;
      return;
    end
    q.d = d; q.addr = {a[31:2], 2'b00}; q.we = mi[3];
    req_q.push_back(q);
    if (d >= MW) begin
      exp_err++;
      return;
    end
    if (mi[3]) begin
      for (int i = 0; i < nb; i++) begin
        b = a + i;
        ref_mem[b[5:2]][8*b[1:0] +: 8] = st[8*i +: 8];
      end
    end else begin
      val = '0;
      for (int i = 0; i < nb; i++) val[8*i +: 8] = get_byte(a + i);
      if (!mi[2] && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      if (v) exp_q.push_back({r, val});
    end
  endtask

  // Bus responder: acks after the delay chosen for each request.
  initial begin
    int idx;
    req_t cur;
    logic [31:0] h_addr, h_wd;
    logic [3:0] h_be;
    logic h_we;
    idx = 0; cur.d = 0; cur.addr = '0; cur.we = 1'b0;
    h_addr = '0; h_wd = '0; h_be = '0; h_we = 1'b0;
    resp_ack = 1'b0; resp_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (!resp_en || !dmem_req) begin
        idx = 0;
      end else begin
        if (idx == 0) begin
          if (req_q.size() == 0) begin
            check("resp_unexpected_req", 1, 0);
            cur.d = 0; cur.addr = dmem_addr; cur.we = dmem_we;
          end else begin
            cur = req_q.pop_front();
          end
          check("resp_addr", dmem_addr, cur.addr);
          check("resp_we", dmem_we, cur.we);
          h_addr = dmem_addr; h_wd = dmem_wdata; h_be = dmem_be; h_we = dmem_we;
        end else begin
          check("resp_hold_data", {dmem_addr, dmem_wdata}, {h_addr, h_wd});
          check("resp_hold_ctl", {dmem_be, dmem_we}, {h_be, h_we});
        end
        if (idx == cur.d) begin
          resp_ack = 1'b1;
          resp_rdata = dmem_we ? $urandom : bus_mem[dmem_addr[5:2]];
          if (dmem_we)
            for (int b = 0; b < 4; b++)
              if (dmem_be[b]) bus_mem[dmem_addr[5:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
          idx = 0;
        end else begin
          idx++;
        end
      end
    end
  end

  // Writeback / error monitor
  always @(negedge clk) begin
    logic [36:0] e;
    if (mon_en) begin
      if (err_m) err_seen++;
      if (wb_v) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", wb_rd, e[36:32]);
          check("wb_data", wb_data, e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] ld_codes[5];
    logic [3:0] st_codes[3];
    logic [3:0] bad_codes[4];
    logic [3:0] mi;
    logic [31:0] a, st;
    logic [4:0] r;
    logic v;
    int d, k, w;
    ld_codes  = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5};
    st_codes  = '{4'd8, 4'd9, 4'd10};
    bad_codes = '{4'd3, 4'd6, 4'd7, 4'd11};
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h1357_9BDF * (i + 1);
      bus_mem[i] = ref_mem[i];
    end
    reset = 1'b0; in_v = 1'b0; minst = '0; rd_data = '0; st_data = '0; rd = '0; rdm_v = 1'b0;
    #12;
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_be", dmem_be, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wb", {wb_v, wb_rd, wb_data}, 0);
    check("rst_err", err_m, 0);
    check("rst_stall", stall_m, 0);
    reset = 1'b1;
    step();

    dir_op("lw", 4'b0010, 32'h100, 0, 32'hDEADBEEF, 2, 4'b1111, 0, 1, 32'hDEADBEEF);
    dir_op("lb", 4'b0000, 32'h103, 0, 32'h80FFFF00, 0, 4'b1000, 0, 1, 32'hFFFFFF80);
    dir_op("lbu", 4'b0100, 32'h103, 0, 32'h80FFFF00, 0, 4'b1000, 0, 1, 32'h00000080);
    dir_op("lh", 4'b0001, 32'h102, 0, 32'h80FFFF00, 1, 4'b1100, 0, 1, 32'hFFFF80FF);
    dir_op("lhu", 4'b0101, 32'h100, 0, 32'h80FFFF00, 0, 4'b0011, 0, 1, 32'h0000FF00);
    dir_op("sh", 4'b1001, 32'h202, 32'h1234ABCD, 0, 1, 4'b1100, 32'hABCDABCD, 0, 0);
    dir_op("sb", 4'b1000, 32'h201, 32'h123456CD, 0, 0, 4'b0010, 32'hCDCDCDCD, 0, 0);
    dir_op("lw_lastack", 4'b0010, 32'h104, 0, 32'h0BADF00D, MW - 1, 4'b1111, 0, 1, 32'h0BADF00D);
    dir_err("mis_lw", 4'b0010, 32'h101);
    dir_err("mis_lh", 4'b0001, 32'h103);
    dir_err("bad_code", 4'b0011, 32'h100);
    dir_err("bad_store", 4'b1011, 32'h100);

    // timeout
    drive(4'b0010, 32'h100, 0, 5'd7, 1'b1);
    step();
    in_v = 1'b0;
    for (int i = 0; i < MW; i++) begin
      check("to_req", dmem_req, 1);
      check("to_stall", stall_m, 1);
      step();
    end
    check("to_req_drop", dmem_req, 0);
    check("to_err", err_m, 1);
    check("to_stall_rel", stall_m, 0);
    check("to_no_wb", wb_v, 0);
    step();
    check("to_err_pulse", err_m, 0);

    // back-to-back ALU results
    drive(4'b1100, 32'h5, 0, 5'd3, 1'b1);
    step();
    check("add1_wb", {wb_v, wb_rd, wb_data}, {1'b1, 5'd3, 32'h5});
    check("add1_stall", stall_m, 0);
    drive(4'b1110, 32'h9, 0, 5'd4, 1'b1);
    step();
    in_v = 1'b0;
    check("add2_wb", {wb_v, wb_rd, wb_data}, {1'b1, 5'd4, 32'h9});
    step();
    check("add_idle", wb_v, 0);

    // reset mid-BUSY, then a stray ack while IDLE
    drive(4'b0010, 32'h100, 0, 5'd7, 1'b1);
    step();
    in_v = 1'b0;
    check("rb_req", dmem_req, 1);
    #1 reset = 1'b0;
    #1;
    check("rb_req_drop", dmem_req, 0);
    check("rb_wb", wb_v, 0);
    check("rb_stall", stall_m, 0);
    #1 reset = 1'b1;
    dir_ack = 1'b1;
    dir_rdata = 32'hFFFF_FFFF;
    step();
    dir_ack = 1'b0;
    check("idle_ack_wb", wb_v, 0);
    check("idle_ack_err", err_m, 0);
    check("idle_ack_req", dmem_req, 0);
    step();

    // random traffic
    resp_en = 1'b1;
    mon_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_v = 1'b0;
        step();
        continue;
      end
      k = $urandom_range(0, 9);
      if (k <= 2) mi = {2'b11, 2'($urandom_range(0, 3))};
      else if (k <= 5) mi = ld_codes[$urandom_range(0, 4)];
      else if (k <= 7) mi = st_codes[$urandom_range(0, 2)];
      else if (k == 8) mi = 4'($urandom_range(0, 15));
      else mi = bad_codes[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a[1:0] = 2'b00;
        1: a[0] = 1'b0;
        default: ;
      endcase
      st = $urandom;
      r = 5'($urandom_range(0, 31));
      v = ($urandom_range(0, 4) != 0);
      d = $urandom_range(0, MW + 1);
      drive(mi, a, st, r, v);
      w = 0;
      while (1) begin
        #3;
        if (!stall_m) begin
          model_op(mi, a, st, r, v, d);
          step();
          break;
        end
        step();
        w++;
        if (w > 3 * MW + 4) begin
          check("drv_stall_bound", 1, 0);
          break;
        end
      end
      in_v = 1'b0;
    end

    w = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0 || dmem_req) && w < 40) begin
      step();
      w++;
    end
    step();
    step();
    check("drain_exp_q", exp_q.size(), 0);
    check("drain_req_q", req_q.size(), 0);
    check("err_count", err_seen, exp_err);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
